// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline register: default payload width
// and the occupancy counter width helper.
package pipe_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Bits needed to count 0..depth valid stages inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_elastic_slot.sv
// One stage of the elastic pipeline: a valid bit and payload register that load
// from their source when the stage is allowed to advance.
module pipe_elastic_slot
   import pipe_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             adv,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Reset beats flush, which beats a normal advance; payload only moves with a valid source.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (flush) begin
         valid <= 1'b0;
         if (CLEAR_DATA) begin
            data <= '0;
         end
      end else if (adv) begin
         valid <= src_valid;
         if (src_valid) begin
            data <= src_data;
         end
      end
   end

endmodule

// File: rtl/pipe_elastic.sv
// DEPTH-stage elastic pipeline with per-stage backpressure, bubble collapse,
// single-cycle flush and occupancy reporting.
module pipe_elastic
   import pipe_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int DEPTH      = 2,
   parameter bit CLEAR_DATA = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int OCC_W = occ_width(DEPTH);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH:0]   adv;
   logic [OCC_W-1:0] count;

   // A stage may load when it is empty or the stage ahead of it is moving.
   always_comb begin
      adv[DEPTH] = out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         adv[i] = ~v[i] | adv[i+1];
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (i == 0) begin : g_head
         assign src_valid = in_valid;
         assign src_data  = in_data;
      end else begin : g_body
         assign src_valid = v[i-1];
         assign src_data  = d[i-1];
      end

      pipe_elastic_slot #(
         .WIDTH      (WIDTH),
         .CLEAR_DATA (CLEAR_DATA)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .adv       (adv[i]),
         .src_valid (src_valid),
         .src_data  (src_data),
         .valid     (v[i]),
         .data      (d[i])
      );
   end

   // Occupancy reflects registered state only, not this cycle's input.
   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         count = count + OCC_W'(v[i]);
      end
   end

   assign in_ready  = adv[0] & ~flush;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_data  = d[DEPTH-1];
   assign occupancy = count;

endmodule

// File: tb/tb_pipe_elastic.sv
// Directed bench for pipe_elastic: three instances (DEPTH=2 clearing, DEPTH=3,
// DEPTH=2 non-clearing) share one stimulus stream; each scenario checks its target.
module tb_pipe_elastic;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        a_in_ready, a_out_valid;
   logic [31:0] a_out_data;
   logic [1:0]  a_occ;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_out_data;
   logic [1:0]  b_occ;
   logic        c_in_ready, c_out_valid;
   logic [31:0] c_out_data;
   logic [1:0]  c_occ;

   int checks = 0;
   int errors = 0;

   pipe_elastic #(.WIDTH(32), .DEPTH(2), .CLEAR_DATA(1'b1)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
      .occupancy(a_occ)
   );

   pipe_elastic #(.WIDTH(32), .DEPTH(3), .CLEAR_DATA(1'b1)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
      .occupancy(b_occ)
   );

   pipe_elastic #(.WIDTH(32), .DEPTH(2), .CLEAR_DATA(1'b0)) dut_c (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
      .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
      .occupancy(c_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock and land just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic iv, input logic [31:0] id,
                                 input logic ordy, input logic fl);
      in_valid  = iv;
      in_data   = id;
      out_ready = ordy;
      flush     = fl;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      do_reset();

      check_output("reset_in_ready",  32'(a_in_ready),  32'd1);
      check_output("reset_out_valid", 32'(a_out_valid), 32'd0);
      check_output("reset_out_data",  a_out_data,       32'h0);
      check_output("reset_occ",       32'(a_occ),       32'd0);

      // Streaming through DEPTH=2: entry k appears at the output two cycles after its offer.
      for (int k = 0; k < 10; k++) begin
         apply_stimulus(k < 8, 32'hA0 + 32'(k), 1'b1, 1'b0);
         if (k < 8) check_output("stream_in_ready", 32'(a_in_ready), 32'd1);
         check_output("stream_out_valid", 32'(a_out_valid), 32'((k >= 2) ? 1 : 0));
         if (k >= 2) check_output("stream_out_data", a_out_data, 32'hA0 + 32'(k - 2));
         tick();
      end

      // Backpressure fill on DEPTH=3.
      do_reset();
      apply_stimulus(1'b1, 32'h11, 1'b0, 1'b0);
      check_output("fill_ready_1", 32'(b_in_ready), 32'd1);
      tick();
      check_output("fill_occ_1", 32'(b_occ), 32'd1);
      apply_stimulus(1'b1, 32'h22, 1'b0, 1'b0);
      check_output("fill_ready_2", 32'(b_in_ready), 32'd1);
      tick();
      check_output("fill_occ_2", 32'(b_occ), 32'd2);
      apply_stimulus(1'b1, 32'h33, 1'b0, 1'b0);
      check_output("fill_ready_3", 32'(b_in_ready), 32'd1);
      tick();
      check_output("fill_occ_3", 32'(b_occ), 32'd3);
      apply_stimulus(1'b1, 32'h44, 1'b0, 1'b0);
      check_output("full_in_ready",  32'(b_in_ready),  32'd0);
      check_output("full_out_valid", 32'(b_out_valid), 32'd1);
      check_output("full_out_data",  b_out_data,       32'h11);
      tick();
      check_output("full_hold_occ",  32'(b_occ), 32'd3);
      check_output("full_hold_data", b_out_data, 32'h11);
      apply_stimulus(1'b1, 32'h44, 1'b1, 1'b0);
      check_output("full_pass_ready", 32'(b_in_ready), 32'd1);
      check_output("full_pass_data",  b_out_data,      32'h11);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check_output("drain_occ_0",  32'(b_occ), 32'd3);
      check_output("drain_data_0", b_out_data, 32'h22);
      tick();
      check_output("drain_data_1", b_out_data, 32'h33);
      tick();
      check_output("drain_data_2", b_out_data, 32'h44);
      tick();
      check_output("drain_empty_occ",   32'(b_occ),       32'd0);
      check_output("drain_empty_valid", 32'(b_out_valid), 32'd0);

      // Bubble collapse on DEPTH=3: 0x55 parked at the output, 0x66 slides up behind it.
      do_reset();
      apply_stimulus(1'b1, 32'h55, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      check_output("bubble_park_occ",  32'(b_occ), 32'd1);
      check_output("bubble_park_data", b_out_data, 32'h55);
      apply_stimulus(1'b1, 32'h66, 1'b0, 1'b0);
      check_output("bubble_in_ready", 32'(b_in_ready), 32'd1);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      check_output("bubble_occ",       32'(b_occ),       32'd2);
      check_output("bubble_out_valid", 32'(b_out_valid), 32'd1);
      check_output("bubble_out_data",  b_out_data,       32'h55);
      tick();
      check_output("bubble_hold_occ", 32'(b_occ), 32'd2);
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      check_output("bubble_next_data", b_out_data, 32'h66);
      check_output("bubble_next_occ",  32'(b_occ), 32'd1);

      // Flush on DEPTH=2, clearing (a) and non-clearing (c) variants.
      do_reset();
      apply_stimulus(1'b1, 32'h77, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h88, 1'b0, 1'b0);
      tick();
      check_output("flush_pre_occ",   32'(a_occ),      32'd2);
      check_output("flush_pre_ready", 32'(a_in_ready), 32'd0);
      apply_stimulus(1'b1, 32'hEE, 1'b0, 1'b1);
      check_output("flush_in_ready_a",  32'(a_in_ready),  32'd0);
      check_output("flush_out_valid_a", 32'(a_out_valid), 32'd0);
      check_output("flush_in_ready_c",  32'(c_in_ready),  32'd0);
      check_output("flush_out_valid_c", 32'(c_out_valid), 32'd0);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      check_output("flush_occ_a",       32'(a_occ),       32'd0);
      check_output("flush_data_a",      a_out_data,       32'h0);
      check_output("flush_valid_a",     32'(a_out_valid), 32'd0);
      check_output("flush_occ_c",       32'(c_occ),       32'd0);
      check_output("flush_data_c",      c_out_data,       32'h77);
      check_output("flush_valid_c",     32'(c_out_valid), 32'd0);
      check_output("flush_in_ready_post", 32'(a_in_ready), 32'd1);

      // Reset mid-stream with flush and in_valid also high.
      do_reset();
      apply_stimulus(1'b1, 32'h12, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h34, 1'b0, 1'b0);
      tick();
      check_output("rst_pre_occ", 32'(a_occ), 32'd2);
      reset = 1'b1;
      apply_stimulus(1'b1, 32'h56, 1'b0, 1'b1);
      tick();
      reset = 1'b0;
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
      check_output("rst_occ",        32'(a_occ),       32'd0);
      check_output("rst_out_valid",  32'(a_out_valid), 32'd0);
      check_output("rst_out_data_a", a_out_data,       32'h0);
      check_output("rst_out_data_c", c_out_data,       32'h0);
      tick();
      check_output("rst_no_accept", 32'(a_occ), 32'd0);

      // Simultaneous transfer on both sides while full.
      do_reset();
      apply_stimulus(1'b1, 32'h31, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h32, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 32'h99, 1'b1, 1'b0);
      check_output("simul_in_ready",  32'(a_in_ready),  32'd1);
      check_output("simul_out_valid", 32'(a_out_valid), 32'd1);
      check_output("simul_out_data",  a_out_data,       32'h31);
      tick();
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check_output("simul_occ",     32'(a_occ), 32'd2);
      check_output("simul_data_1",  a_out_data, 32'h32);
      tick();
      check_output("simul_data_2",  a_out_data, 32'h99);
      check_output("simul_occ_2",   32'(a_occ), 32'd1);
      tick();
      check_output("simul_empty",   32'(a_occ), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_elastic.md
Name: pipe_elastic

Overview:
- Parametrised DEPTH-stage elastic pipeline register with valid/ready handshake.
- Successor to the fixed stall/flush pipeline flops: stall is now per-stage backpressure rather than a global signal.
- Bubbles collapse, flush is a single squash, and occupancy is reported.
- Sits between processor pipeline stages, e.g. fetch→decode queueing, or wherever a variable-latency consumer needs buffering.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 2, number of register stages; legal range ≥1.
- CLEAR_DATA, 1, if 1 flush zeroes payload registers; if 0 flush clears only valid bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- flush  input  1  squash all in-flight entries this cycle.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- in_data  input  WIDTH  payload in.
- out_valid  output  1  stage DEPTH-1 holds a valid entry.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  payload of stage DEPTH-1.
- occupancy  output  $clog2(DEPTH+1)  count of valid stages.

Behaviour:
- State per stage i (0..DEPTH-1): v[i] and d[i]. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Advance chain, combinational:
  - adv[DEPTH] = out_ready.
  - adv[i] = ~v[i] | adv[i+1].
- in_ready = adv[0] & ~flush.
- out_valid = v[DEPTH-1] & ~flush.
- out_data = d[DEPTH-1].
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Normal update, when not reset and not flush, for each i with adv[i]:
  - v[i] <= source valid; d[i] <= source data.
  - Source is stage i-1, or in_valid/in_data for i=0.
  - d[i] updates only when the source valid is 1; otherwise it holds.
- Stages with adv[i]=0 hold v and d.
- Latency: an entry accepted into an empty pipe at edge N shows out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from acceptance to presentation counting the accept edge.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- Bubble collapse: a stalled output does not stall earlier stages that have an empty stage ahead of them. Full stall occurs only when all DEPTH stages are valid and out_ready=0.
- Full condition: all v=1 and out_ready=0 → in_ready=0.
- Full with out_ready=1: in_ready=1 (pass-through of readiness, same cycle).
- Empty: out_valid=0, occupancy=0, in_ready=1 (unless flush).
- Flush (priority over normal update):
  - All v <= 0 at the edge.
  - in_ready=0 and out_valid=0 during the flush cycle, so no transfer occurs on either side.
  - If CLEAR_DATA=1, all d <= 0; else d holds.
- Reset (priority over flush): all v <= 0 and all d <= 0 regardless of CLEAR_DATA. Reset mid-stream discards everything.
- Reset values:
  - in_ready=1 (after reset deasserts; combinational from v=0)
  - out_valid=0
  - out_data=0
  - occupancy=0
- occupancy = popcount(v), registered-state based (not including same-cycle input).
- Occupancy never exceeds DEPTH.
- DEPTH=1 degenerates to a single ready-chained register with flush.

Decomposition:
- Package pipe_pkg holds occupancy-width helper function and a localparam default WIDTH shared with datapath stages.
- One natural sub-module: pipe_elastic_slot, containing one stage's v/d registers with reset/flush/advance/CLEAR_DATA logic. Instantiated DEPTH times via generate.
- Advance chain and popcount live in the top module.

Test Plan:
- Streaming: DEPTH=2, out_ready=1, drive 0xA0..0xA7 back-to-back.
  - out_data emits 0xA0..0xA7 in order on consecutive cycles.
  - First out_valid appears 2 cycles after the first accept.
  - in_ready stays 1 throughout.
- Backpressure fill: DEPTH=3, out_ready=0, offer 0x11,0x22,0x33,0x44.
  - First three accepted; occupancy steps 1,2,3.
  - in_ready=0 with 0x44 held.
  - Raising out_ready outputs 0x11 and accepts 0x44 in the same cycle.
- Bubble collapse: DEPTH=3, one entry 0x55 at the output stage, out_ready=0, offer 0x66.
  - 0x66 is accepted and advances to stage 1 in 2 cycles.
  - occupancy=2; 0x55 is still presented.
- Flush: DEPTH=2 full with 0x77,0x88, assert flush 1 cycle with in_valid=1.
  - in_ready=0 and out_valid=0 that cycle.
  - Next cycle occupancy=0.
  - With CLEAR_DATA=1, out_data=0; with CLEAR_DATA=0, out_data=0x77 and out_valid=0.
- Reset mid-operation: 2 entries in flight, assert reset while flush=1 and in_valid=1.
  - Next cycle all v=0, out_data=0, occupancy=0.
  - No entry accepted.
- Simultaneous in/out when full: DEPTH=2, full, out_ready=1, in_valid=1 with 0x99.
  - Output transfers, 0x99 is accepted, occupancy stays 2.
  - 0x99 emerges 2 transfers later.
